div_unit: RTL and testbench



---
 rtl/div_pkg.sv | 11 +
 rtl/div_step.sv | 23 ++
 rtl/div_unit.sv | 123 ++++++++++++
 tb/tb_div_unit.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared types and helpers for the sequential restoring divider.
package div_pkg;

  typedef enum logic [1:0] {S_IDLE, S_ITER, S_FIX, S_DONE} div_st_t;

  // Iteration counter width: it must hold values 0..width-1.
  function automatic int cnt_bits(input int width);
    return (width > 2) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift in the next dividend bit, then trial-subtract the divisor.
module div_step #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH:0]   rem_in,
  input  logic             bit_in,
  input  logic [WIDTH-1:0] dvs,
  output logic [WIDTH:0]   rem_out,
  output logic             q_bit
);

  logic [WIDTH:0]   sh;
  logic [WIDTH+1:0] diff;
  logic             unused_msb;

  // The remainder stays below the divisor magnitude, so its top bit is shifted out as zero.
  assign unused_msb = rem_in[WIDTH];
  assign sh         = {rem_in[WIDTH-1:0], bit_in};
  assign diff       = {1'b0, sh} - {2'b00, dvs};
  assign q_bit      = ~diff[WIDTH+1];
  assign rem_out    = q_bit ? diff[WIDTH:0] : sh;

endmodule

// File: rtl/div_unit.sv
// Multi-cycle signed/unsigned divider: one quotient bit per cycle, start/done handshake, abort.
module div_unit
  import div_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter bit SIGNED_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             signed_mode,
  input  logic             abort,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic             ovf
);

  localparam int CW = cnt_bits(WIDTH);

  div_st_t          state, nxt;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_sh, b_mag, min_val;
  logic [WIDTH:0]   rem, rem_nxt;
  logic             q_bit, neg_q, neg_r, ovf_pend;
  logic             sm, a_neg, b_neg, accept, zero_dvs, last_iter;

  assign sm        = SIGNED_EN && signed_mode;
  assign a_neg     = sm && dividend[WIDTH-1];
  assign b_neg     = sm && divisor[WIDTH-1];
  assign min_val   = {1'b1, {(WIDTH-1){1'b0}}};
  assign ready     = (state == S_IDLE) || (state == S_DONE);
  assign busy      = (state == S_ITER) || (state == S_FIX);
  assign done      = (state == S_DONE);
  assign accept    = start && ready;
  assign zero_dvs  = (divisor == '0);
  assign last_iter = (cnt == CW'(WIDTH-1));

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_in (rem),
    .bit_in (a_sh[WIDTH-1]),
    .dvs    (b_mag),
    .rem_out(rem_nxt),
    .q_bit  (q_bit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      S_IDLE: if (start) nxt = zero_dvs ? S_DONE : S_ITER;
      S_ITER: if (abort) nxt = S_IDLE; else if (last_iter) nxt = S_FIX;
      S_FIX:  nxt = abort ? S_IDLE : S_DONE;
      S_DONE: nxt = start ? (zero_dvs ? S_DONE : S_ITER) : S_IDLE;
      default: nxt = S_IDLE;
    endcase
  end

  // a_sh starts as |dividend| and fills with quotient bits from the bottom as it shifts out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt         <= '0;
      a_sh        <= '0;
      b_mag       <= '0;
      rem         <= '0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      ovf_pend    <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      ovf         <= 1'b0;
    end else if (accept) begin
      neg_q    <= a_neg ^ b_neg;
      neg_r    <= a_neg;
      a_sh     <= a_neg ? -dividend : dividend;
      b_mag    <= b_neg ? -divisor : divisor;
      rem      <= '0;
      cnt      <= '0;
      ovf      <= 1'b0;
      ovf_pend <= sm && (dividend == min_val) && (divisor == '1);
      div_by_zero <= zero_dvs;
      if (zero_dvs) begin
        quotient  <= '1;
        remainder <= dividend;
      end
    end else begin
      case (state)
        S_ITER: begin
          if (abort) begin
            div_by_zero <= 1'b0;
            ovf         <= 1'b0;
          end else begin
            rem  <= rem_nxt;
            a_sh <= {a_sh[WIDTH-2:0], q_bit};
            cnt  <= cnt + 1'b1;
          end
        end
        S_FIX: begin
          if (abort) begin
            div_by_zero <= 1'b0;
            ovf         <= 1'b0;
          end else begin
            quotient  <= neg_q ? -a_sh : a_sh;
            remainder <= neg_r ? -rem[WIDTH-1:0] : rem[WIDTH-1:0];
            ovf       <= ovf_pend;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit (WIDTH=8): directed cases, randomized traffic, abort and reset.
module tb_div_unit;

  localparam int W = 8;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dbz;
    logic         ovf;
    int           due;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         start = 1'b0, signed_mode = 1'b0, abort = 1'b0;
  logic [W-1:0] dividend = '0, divisor = '0;
  logic         ready, busy, done, div_by_zero, ovf;
  logic [W-1:0] quotient, remainder;

  exp_t         sb[$];
  int           total = 0, bad = 0, cyc = 0;
  logic [W-1:0] last_q = '0, last_r = '0;

  div_unit #(.WIDTH(W), .SIGNED_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .signed_mode(signed_mode), .abort(abort),
    .dividend(dividend), .divisor(divisor), .ready(ready), .busy(busy), .done(done),
    .quotient(quotient), .remainder(remainder), .div_by_zero(div_by_zero), .ovf(ovf)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // C-style truncating division computed with plain integer arithmetic.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic sm);
    exp_t e;
    int sa, sbv, qi, ri;
    e.dbz = 1'b0;
    e.ovf = 1'b0;
    e.due = 0;
    if (b == 0) begin
      e.q = '1;
      e.r = a;
      e.dbz = 1'b1;
    end else if (sm) begin
      sa = $signed(a);
      sbv = $signed(b);
      qi = sa / sbv;
      ri = sa % sbv;
      e.q = qi[W-1:0];
      e.r = ri[W-1:0];
      e.ovf = (sa == -(1 << (W-1))) && (sbv == -1);
    end else begin
      e.q = a / b;
      e.r = a % b;
    end
    return e;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (done) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_done: q=0x%0h r=0x%0h with no pending operation", quotient, remainder);
        end else begin
          e = sb.pop_front();
          chk("done_cycle", cyc, e.due);
          chk("quotient", quotient, e.q);
          chk("remainder", remainder, e.r);
          chk("div_by_zero", div_by_zero, e.dbz);
          chk("ovf", ovf, e.ovf);
          last_q = e.q;
          last_r = e.r;
        end
      end else if (sb.size() > 0 && cyc > sb[0].due) begin
        e = sb.pop_front();
        total++;
        bad++;
        $display("FAIL done_timeout: no done by cycle %0d, expected at %0d", cyc, e.due);
      end
    end
  end

  // Called on a negedge; waits for ready, presents one request, returns on the negedge after accept.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic sm,
                       input bit push, input logic ab);
    exp_t e;
    int n = 0;
    while (!ready && n < 100) begin @(negedge clk); n++; end
    if (!ready) begin
      total++;
      bad++;
      $display("FAIL ready_timeout: ready=%0b required 1", ready);
      return;
    end
    dividend = a; divisor = b; signed_mode = sm; start = 1'b1; abort = ab;
    if (push) begin
      e = model(a, b, sm);
      e.due = cyc + ((b == 0) ? 1 : W + 2);
      sb.push_back(e);
    end
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    dividend = W'($urandom); divisor = W'($urandom); signed_mode = 1'($urandom);
    if (b == 0) chk("dbz_no_busy", busy, 0);
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((sb.size() != 0 || done || !ready) && n < 300) begin @(negedge clk); n++; end
    chk("drain", sb.size(), 0);
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_ready", ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_q", quotient, 0);
    chk("rst_r", remainder, 0);
    chk("rst_flags", {div_by_zero, ovf}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed cases, issued back-to-back (each start lands in the previous S_DONE cycle).
    issue(8'd100, 8'd7,  1'b0, 1, 1'b0);
    issue(8'h9C,  8'd7,  1'b1, 1, 1'b0);
    issue(8'd100, 8'hF9, 1'b1, 1, 1'b0);
    issue(8'd55,  8'd0,  1'b0, 1, 1'b0);
    issue(8'd55,  8'd0,  1'b1, 1, 1'b0);
    issue(8'h80,  8'hFF, 1'b1, 1, 1'b0);
    issue(8'h80,  8'hFF, 1'b0, 1, 1'b0);
    issue(8'd200, 8'd3,  1'b0, 1, 1'b0);
    issue(8'd9,   8'd4,  1'b0, 1, 1'b0);
    wait_idle();

    // Abort on edge 4: no done, ready right after, earlier results kept, flags cleared.
    issue(8'd50, 8'd3, 1'b0, 0, 1'b0);
    repeat (3) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_ready", ready, 1);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_q_kept", quotient, last_q);
    chk("abort_r_kept", remainder, last_r);
    chk("abort_flags", {div_by_zero, ovf}, 0);
    repeat (W + 4) @(negedge clk);

    // Asynchronous reset in the middle of an operation.
    issue(8'd77, 8'd5, 1'b0, 0, 1'b0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_ready", ready, 1);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_q", quotient, 0);
    chk("mid_rst_r", remainder, 0);
    chk("mid_rst_flags", {div_by_zero, ovf}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Randomized traffic with corner-biased operands, idle gaps and stray aborts alongside start.
    for (int i = 0; i < 60; i++) begin
      ra = ($urandom_range(0, 5) == 0) ? 8'h80 : W'($urandom);
      case ($urandom_range(0, 7))
        0:       rb = 8'h00;
        1:       rb = 8'hFF;
        2:       rb = 8'h80;
        3:       rb = W'($urandom_range(1, 3));
        default: rb = W'($urandom);
      endcase
      issue(ra, rb, 1'($urandom), 1, 1'($urandom_range(0, 3) == 0));
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 12)) @(negedge clk);
    end
    wait_idle();
    repeat (3) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
